// File: rtl/cf_pkg.sv
// Shared Connect-Four definitions for the column drop controller.
// Holds the board geometry, derived field widths, the player and drop-state
// encodings, and the helper that maps a (row, column) cell to its bit
// position in the flattened occupancy vectors.
package cf_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  // Heights must hold the value ROWS itself (a full column).
  localparam int HGT_W = $clog2(ROWS + 1);

  typedef enum logic {
    RED   = 1'b0,
    GREEN = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DROP = 2'd1,
    LAND = 2'd2
  } drop_state_t;

  // Row 0 is the bottom row; bit index is row*COLS + col.
  function automatic int cell_idx(input logic [ROW_W-1:0] row,
                                  input logic [COL_W-1:0] col);
    return int'(row) * COLS + int'(col);
  endfunction

endpackage

// File: rtl/drop_tick_timer.sv
// Modulo-TICKS counter pacing the falling-token animation, one row per wrap.
// Only present when DROP_ANIM_EN is defined; builds without the animation
// have no use for it.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   clear - holds the count at zero (asserted whenever no drop is running)
//   wrap  - high in the cycle where the count sits at TICKS-1
`ifdef DROP_ANIM_EN
module drop_tick_timer #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic wrap
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wrap = !clear && (cnt == LAST);

endmodule
`endif

// File: rtl/column_drop_ctrl.sv
// Connect-Four column drop controller.
// Turns one-cycle column-select pulses into token drops for the side to
// move, optionally animates the falling token, commits it to the occupancy
// boards, then hands the turn to the other player.
// Build option: DROP_ANIM_EN -- when defined the token visibly falls one row
// every DROP_TICKS cycles; when undefined an accepted pulse lands directly.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   col_pulse     - one-cycle column-select pulses, one bit per column
//   enable        - 0 freezes the game (selections ignored in IDLE)
//   red_board     - player-0 occupancy, bit [r*COLS+c]
//   green_board   - player-1 occupancy, same indexing
//   fall_active   - a falling token is on display
//   fall_row/col  - position of the falling token
//   player        - side to move (0 = red, 1 = green)
//   move_done     - one-cycle pulse in the landing cycle
//   move_col/row  - last landed cell, held until the next landing
//   move_reject   - one-cycle pulse for an invalid selection
//   board_full    - every cell occupied
module column_drop_ctrl
  import cf_pkg::*;
#(
  parameter int DROP_TICKS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COLS-1:0]      col_pulse,
  input  logic                 enable,
  output logic [ROWS*COLS-1:0] red_board,
  output logic [ROWS*COLS-1:0] green_board,
  output logic                 fall_active,
  output logic [ROW_W-1:0]     fall_row,
  output logic [COL_W-1:0]     fall_col,
  output logic                 player,
  output logic                 move_done,
  output logic [COL_W-1:0]     move_col,
  output logic [ROW_W-1:0]     move_row,
  output logic                 move_reject,
  output logic                 board_full
);

  drop_state_t          state, next_state;
  player_t              player_q;
  logic [HGT_W-1:0]     height [COLS];
  logic [ROWS*COLS-1:0] red_q, green_q, land_mask;
  logic [COL_W-1:0]     col_q, sel_col, tgt_col, move_col_q;
  logic [ROW_W-1:0]     tgt_row, move_row_q;
  logic                 accept, reject_now, enter_land;
  logic                 reject_q, full_q;

`ifdef DROP_ANIM_EN
  logic [ROW_W-1:0] fall_row_q;
  logic             tick_wrap;

  drop_tick_timer #(
    .TICKS(DROP_TICKS)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state != DROP),
    .wrap (tick_wrap)
  );
`else
  localparam int unused_drop_ticks = DROP_TICKS;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    sel_col    = '0;
    accept     = 1'b0;
    reject_now = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (col_pulse[c]) sel_col = COL_W'(c);
    end
    case (state)
      IDLE: begin
        if (enable && (col_pulse != '0)) begin
          // A full board implies every column is full, but the explicit
          // flag keeps the rejection independent of the height lookup.
          if (!$onehot(col_pulse) || full_q ||
              (height[sel_col] == HGT_W'(ROWS))) begin
            reject_now = 1'b1;
          end else begin
            accept = 1'b1;
`ifdef DROP_ANIM_EN
            next_state = DROP;
`else
            next_state = LAND;
`endif
          end
        end
      end
`ifdef DROP_ANIM_EN
      DROP: begin
        if (tick_wrap && (HGT_W'(fall_row_q) == height[col_q])) begin
          next_state = LAND;
        end
      end
`endif
      LAND:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Without animation the landing column comes straight from the pulse.
    tgt_col    = (state == IDLE) ? sel_col : col_q;
    tgt_row    = ROW_W'(height[tgt_col]);
    enter_land = (next_state == LAND) && (state != LAND);
    land_mask  = (ROWS*COLS)'(1) << cell_idx(tgt_row, tgt_col);
  end

  // The board bit is written on entry to LAND so it is visible during the
  // landing cycle; height and turn advance as LAND is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) height[c] <= '0;
      red_q      <= '0;
      green_q    <= '0;
      player_q   <= RED;
      col_q      <= '0;
      move_col_q <= '0;
      move_row_q <= '0;
      reject_q   <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      reject_q <= reject_now;
      full_q   <= &(red_q | green_q);
      if (accept) col_q <= sel_col;
      if (enter_land) begin
        if (player_q == RED) red_q <= red_q | land_mask;
        else                 green_q <= green_q | land_mask;
        move_col_q <= tgt_col;
        move_row_q <= tgt_row;
      end
      if (state == LAND) begin
        height[col_q] <= height[col_q] + 1'b1;
        player_q      <= (player_q == RED) ? GREEN : RED;
      end
    end
  end

`ifdef DROP_ANIM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fall_row_q <= '0;
    end else if (accept) begin
      fall_row_q <= ROW_W'(ROWS - 1);
    end else if ((state == DROP) && tick_wrap && (next_state != LAND)) begin
      fall_row_q <= fall_row_q - 1'b1;
    end
  end

  assign fall_active = (state == DROP);
  assign fall_row    = fall_row_q;
  assign fall_col    = col_q;
`else
  assign fall_active = 1'b0;
  assign fall_row    = '0;
  assign fall_col    = '0;
`endif

  assign red_board   = red_q;
  assign green_board = green_q;
  assign player      = player_q;
  assign move_done   = (state == LAND);
  assign move_col    = move_col_q;
  assign move_row    = move_row_q;
  assign move_reject = reject_q;
  assign board_full  = full_q;

endmodule

// File: tb/tb_column_drop_ctrl.sv
// Self-checking bench for column_drop_ctrl with DROP_TICKS=2 on an 8x8 board.
// Expected landings and rejects are queued as stimulus is driven and retired
// by a monitor when the DUT reports them; fall-animation timing is checked
// cycle by cycle when DROP_ANIM_EN is defined.
module tb_column_drop_ctrl;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int TICKS = 2;
  localparam int CELLS = ROWS * COLS;

  logic             clk;
  logic             reset;
  logic [COLS-1:0]  col_pulse;
  logic             enable;
  logic [CELLS-1:0] red_board, green_board;
  logic             fall_active;
  logic [2:0]       fall_row, fall_col, move_col, move_row;
  logic             player, move_done, move_reject, board_full;

  column_drop_ctrl #(
    .DROP_TICKS(TICKS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .col_pulse  (col_pulse),
    .enable     (enable),
    .red_board  (red_board),
    .green_board(green_board),
    .fall_active(fall_active),
    .fall_row   (fall_row),
    .fall_col   (fall_col),
    .player     (player),
    .move_done  (move_done),
    .move_col   (move_col),
    .move_row   (move_row),
    .move_reject(move_reject),
    .board_full (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [COLS-1:0] pulse;
    logic            en;
    bit              exp_land;
    bit              exp_reject;
    int              exp_row;
  } vec_t;

  typedef struct {
    int col;
    int row;
    bit plyr;
  } land_t;

  int         n_checks = 0;
  int         n_fails  = 0;
  land_t      sb_q[$];
  int         rej_pending = 0;
  int         model_h[COLS];
  bit         model_player;
  int         model_count;
  logic [CELLS-1:0] exp_red, exp_green;
  vec_t       vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < COLS; c++) model_h[c] = 0;
    model_player = 1'b0;
    model_count  = 0;
    exp_red      = '0;
    exp_green    = '0;
    sb_q.delete();
    rej_pending  = 0;
  endtask

  // Retires scoreboard entries as the DUT lands tokens or rejects pulses.
  always @(negedge clk) begin
    land_t e;
    if (!reset) begin
      checkOutput("board_overlap", red_board & green_board, '0);
      if (move_done) begin
        checkOutput("landing_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (e.plyr) exp_green[e.row*COLS+e.col] = 1'b1;
          else        exp_red[e.row*COLS+e.col]   = 1'b1;
          checkOutput("move_col", move_col, e.col);
          checkOutput("move_row", move_row, e.row);
          checkOutput("red_board", red_board, exp_red);
          checkOutput("green_board", green_board, exp_green);
        end
      end
      if (move_reject) begin
        checkOutput("reject_expected", rej_pending > 0, 1);
        if (rej_pending > 0) rej_pending--;
      end
    end
  end

  // spur: 1 = stray pulse on column 5 mid-fall, 2 = stray pulse in LAND cycle
  task automatic do_move(input int col, input int exp_row, input int spur);
    land_t e;
    int lat, n;
    e.col = col; e.row = exp_row; e.plyr = model_player;
    sb_q.push_back(e);
    model_h[col]++;
    model_player = !model_player;
    model_count++;
`ifdef DROP_ANIM_EN
    lat = (ROWS - exp_row) * TICKS + 1;
`else
    lat = 1;
`endif
    @(negedge clk);
    col_pulse = '0;
    col_pulse[col] = 1'b1;
    @(negedge clk);
    col_pulse = '0;
    n = 1;
    while (!move_done && n < lat + 8) begin
`ifdef DROP_ANIM_EN
      checkOutput("fall_active", fall_active, 1);
      checkOutput("fall_row", fall_row, 7 - (n - 1) / TICKS);
      checkOutput("fall_col", fall_col, col);
      if (spur == 1 && n == 3) col_pulse = 8'b0010_0000;
      else                     col_pulse = '0;
`endif
      @(negedge clk);
      n++;
    end
    col_pulse = '0;
    checkOutput("move_done", move_done, 1);
    checkOutput("move_latency", n, lat);
    checkOutput("fall_active_land", fall_active, 0);
    checkOutput("board_full_land", board_full, 0);
    if (spur == 2) col_pulse = 8'b0010_0000;
    @(negedge clk);
    col_pulse = '0;
    checkOutput("move_done_pulse", move_done, 0);
    checkOutput("idle_after_land", fall_active, 0);
    checkOutput("player", player, model_player);
    checkOutput("board_full", board_full, model_count == CELLS);
    checkOutput("sb_drained", sb_q.size(), 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int c = 0;
    for (int i = 0; i < COLS; i++) if (v.pulse[i]) c = i;
    if (v.exp_land) begin
      do_move(c, v.exp_row, 0);
    end else begin
      if (v.exp_reject) rej_pending++;
      @(negedge clk);
      col_pulse = v.pulse;
      enable    = v.en;
      @(negedge clk);
      col_pulse = '0;
      enable    = 1'b1;
      checkOutput("move_reject", move_reject, v.exp_reject);
      checkOutput("no_drop", fall_active, 0);
      @(negedge clk);
      checkOutput("reject_one_cycle", move_reject, 0);
      checkOutput("reject_drained", rej_pending, 0);
      checkOutput("player_hold", player, model_player);
      checkOutput("red_hold", red_board, exp_red);
      checkOutput("green_hold", green_board, exp_green);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'b0000_1000, 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{8'b0000_1000, 1'b1, 1'b1, 1'b0, 1};
    vecs[2] = '{8'b0000_0101, 1'b1, 1'b0, 1'b1, 0};
    vecs[3] = '{8'b0001_0000, 1'b0, 1'b0, 1'b0, 0};
    vecs[4] = '{8'b1000_0000, 1'b1, 1'b1, 1'b0, 0};
    vecs[5] = '{8'b1111_1111, 1'b1, 1'b0, 1'b1, 0};
    vecs[6] = '{8'b0000_1000, 1'b1, 1'b1, 1'b0, 2};
    vecs[7] = '{8'b0000_0000, 1'b1, 1'b0, 1'b0, 0};

    reset = 1'b1;
    col_pulse = '0;
    enable = 1'b1;
    clear_model();
    repeat (3) @(negedge clk);
    checkOutput("rst_player", player, 0);
    checkOutput("rst_red", red_board, '0);
    checkOutput("rst_green", green_board, '0);
    checkOutput("rst_fall_active", fall_active, 0);
    checkOutput("rst_fall_row", fall_row, 0);
    checkOutput("rst_move_done", move_done, 0);
    checkOutput("rst_move_col", move_col, 0);
    checkOutput("rst_move_reject", move_reject, 0);
    checkOutput("rst_board_full", board_full, 0);
    reset = 1'b0;

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] fill column 0 then overfill");
    for (int r = 0; r < ROWS; r++) do_move(0, r, 0);
    applyStimulus('{8'b0000_0001, 1'b1, 1'b0, 1'b1, 0});

    $display("[TB] stray pulses while a token is in flight");
`ifdef DROP_ANIM_EN
    do_move(2, 0, 1);
    do_move(2, 1, 2);
`else
    do_move(2, 0, 2);
`endif

    $display("[TB] reset during a move");
    @(negedge clk);
    col_pulse = 8'b0100_0000;
`ifdef DROP_ANIM_EN
    @(negedge clk);
    col_pulse = '0;
    repeat (2) @(negedge clk);
    checkOutput("mid_drop_active", fall_active, 1);
    reset = 1'b1;
`else
    reset = 1'b1;
`endif
    @(negedge clk);
    col_pulse = '0;
    checkOutput("abort_fall_active", fall_active, 0);
    checkOutput("abort_move_done", move_done, 0);
    checkOutput("abort_red", red_board, '0);
    checkOutput("abort_green", green_board, '0);
    checkOutput("abort_player", player, 0);
    checkOutput("abort_move_col", move_col, 0);
    reset = 1'b0;
    clear_model();
    repeat (20) @(negedge clk);
    checkOutput("abort_stays_idle", fall_active, 0);

    $display("[TB] fill whole board");
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) do_move(c, r, 0);
    applyStimulus('{8'b0001_0000, 1'b1, 1'b0, 1'b1, 0});
    applyStimulus('{8'b0000_0101, 1'b1, 1'b0, 1'b1, 0});
    checkOutput("full_held", board_full, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
